// File: rtl/if1_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// if1_fetch_ctrl_pkg
// Shared definitions for the IF1 fetch controller:
//   WORD      - data/address width
//   PC_RST    - architectural fetch PC after reset
//   fetch_state_t - fetch FSM encoding (REQ/WAIT/HOLD/DROP)
//   pc_next_seq() - sequential next-PC helper (32-bit modulo)
// ---------------------------------------------------------------------------
package if1_fetch_ctrl_pkg;

   localparam int          WORD   = 32;
   localparam logic [31:0] PC_RST = 32'h1C00_0000;

   typedef enum logic [1:0] {
      FETCH_REQ  = 2'd0,   // ready to issue a request for pc
      FETCH_WAIT = 2'd1,   // request outstanding, waiting for the response
      FETCH_HOLD = 2'd2,   // response captured while the pipeline is stalled
      FETCH_DROP = 2'd3    // redirected while a stale response is in flight
   } fetch_state_t;

   // Sequential fetch: the next word. Wraps naturally at 2^32.
   function automatic logic [WORD-1:0] pc_next_seq(input logic [WORD-1:0] pc);
      return pc + WORD'(4);
   endfunction

endpackage

// File: rtl/if1_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if1_fetch_ctrl
// Owns the architectural fetch PC, issues one-at-a-time ICache requests and
// offers PC/instruction pairs to the IF1/ID pipeline register. Absorbs ICache
// latency, EX-stage redirects and downstream stalls.
//
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   stall_from_DCache/Load     - downstream stalls (same as IF1/ID receives)
//   redirect_valid/target      - EX branch redirect and new fetch PC
//   icache_req_valid/addr      - request to the ICache
//   icache_req_ready           - ICache accepts the request this cycle
//   icache_resp_valid/inst     - returned instruction (one per request)
//   IF1_PC_out/IF1_inst_out    - PC/instruction offered to IF1/ID
//   IF1_bubble_out             - 1 when no valid instruction is offered
// ---------------------------------------------------------------------------
module if1_fetch_ctrl
   import if1_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] P_PC_RST = PC_RST
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_from_DCache,
   input  logic            stall_from_Load,
   input  logic            redirect_valid,
   input  logic [WORD-1:0] redirect_target,
   output logic            icache_req_valid,
   output logic [WORD-1:0] icache_req_addr,
   input  logic            icache_req_ready,
   input  logic            icache_resp_valid,
   input  logic [WORD-1:0] icache_resp_inst,
   output logic [WORD-1:0] IF1_PC_out,
   output logic [WORD-1:0] IF1_inst_out,
   output logic            IF1_bubble_out
);

   fetch_state_t    r_state,    w_state_nxt;
   logic [WORD-1:0] r_pc,       w_pc_nxt;
   logic [WORD-1:0] r_buf_inst, w_buf_inst_nxt;

   logic            w_stall;
   logic [WORD-1:0] w_target;

   // A redirect masks the load stall: the load that stalled is being flushed.
   // Same rule as the IF1/ID register so both advance in lockstep.
   assign w_stall  = stall_from_DCache | (~redirect_valid & stall_from_Load);
   assign w_target = {redirect_target[WORD-1:2], 2'b00};

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; reset is synchronous, so it sits inside the clocked branch.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= FETCH_REQ;
         r_pc       <= P_PC_RST;
         r_buf_inst <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_buf_inst <= w_buf_inst_nxt;
      end
   end

   // Next-state, next-PC mux (target / pc+4 / pc) and outputs.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // through the case can leave one unassigned and infer a latch.
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_buf_inst_nxt   = r_buf_inst;
      icache_req_valid = 1'b0;
      icache_req_addr  = r_pc;
      IF1_PC_out       = r_pc;
      IF1_inst_out     = '0;
      IF1_bubble_out   = 1'b1;

      unique case (r_state)
         FETCH_REQ: begin
            // Never issue a request with the PC a redirect is replacing.
            icache_req_valid = ~redirect_valid;
            if (redirect_valid) begin
               w_pc_nxt = w_target;
            end else if (icache_req_ready) begin
               w_state_nxt = FETCH_WAIT;
            end
         end

         FETCH_WAIT: begin
            if (redirect_valid) begin
               w_pc_nxt    = w_target;
               // If the response is already here it is dropped now; otherwise
               // it is still in flight and must be swallowed in DROP.
               w_state_nxt = icache_resp_valid ? FETCH_REQ : FETCH_DROP;
            end else if (icache_resp_valid) begin
               IF1_inst_out   = icache_resp_inst;
               IF1_bubble_out = 1'b0;
               if (!w_stall) begin
                  w_pc_nxt    = pc_next_seq(r_pc);
                  w_state_nxt = FETCH_REQ;
               end else begin
                  w_buf_inst_nxt = icache_resp_inst;
                  w_state_nxt    = FETCH_HOLD;
               end
            end
         end

         FETCH_HOLD: begin
            IF1_inst_out   = r_buf_inst;
            IF1_bubble_out = 1'b0;
            if (redirect_valid) begin
               // IF1/ID flushes on the same redirect, so the held word is lost.
               w_pc_nxt    = w_target;
               w_state_nxt = FETCH_REQ;
            end else if (!w_stall) begin
               w_pc_nxt    = pc_next_seq(r_pc);
               w_state_nxt = FETCH_REQ;
            end
         end

         FETCH_DROP: begin
            if (redirect_valid) begin
               w_pc_nxt = w_target;
            end
            if (icache_resp_valid) begin
               w_state_nxt = FETCH_REQ;
            end
         end

         default: begin
            w_state_nxt = FETCH_REQ;
         end
      endcase
   end

endmodule

// File: tb/tb_if1_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_if1_fetch_ctrl
// Directed self-checking bench for if1_fetch_ctrl. Inputs change 1 time unit
// after the rising edge; outputs are sampled 1 unit after that.
// ---------------------------------------------------------------------------
module tb_if1_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_from_DCache;
   logic        stall_from_Load;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        icache_req_valid;
   logic [31:0] icache_req_addr;
   logic        icache_req_ready;
   logic        icache_resp_valid;
   logic [31:0] icache_resp_inst;
   logic [31:0] IF1_PC_out;
   logic [31:0] IF1_inst_out;
   logic        IF1_bubble_out;

   int vectors     = 0;
   int miscompares = 0;

   if1_fetch_ctrl dut (
      .clk               (clk),
      .rst               (rst),
      .stall_from_DCache (stall_from_DCache),
      .stall_from_Load   (stall_from_Load),
      .redirect_valid    (redirect_valid),
      .redirect_target   (redirect_target),
      .icache_req_valid  (icache_req_valid),
      .icache_req_addr   (icache_req_addr),
      .icache_req_ready  (icache_req_ready),
      .icache_resp_valid (icache_resp_valid),
      .icache_resp_inst  (icache_resp_inst),
      .IF1_PC_out        (IF1_PC_out),
      .IF1_inst_out      (IF1_inst_out),
      .IF1_bubble_out    (IF1_bubble_out)
   );

   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed no end, required end");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic check_offer(input string tag, input logic bub, input logic [31:0] pc,
                              input logic [31:0] inst);
      check({tag, "_bubble"}, {31'd0, IF1_bubble_out}, {31'd0, bub});
      check({tag, "_pc"},     IF1_PC_out,   pc);
      check({tag, "_inst"},   IF1_inst_out, inst);
   endtask

   task automatic check_req(input string tag, input logic vld, input logic [31:0] addr);
      check({tag, "_req_valid"}, {31'd0, icache_req_valid}, {31'd0, vld});
      check({tag, "_req_addr"},  icache_req_addr, addr);
   endtask

   initial begin
      rst = 1'b1;
      stall_from_DCache = 1'b0;
      stall_from_Load   = 1'b0;
      redirect_valid    = 1'b0;
      redirect_target   = 32'h0;
      icache_req_ready  = 1'b0;
      icache_resp_valid = 1'b0;
      icache_resp_inst  = 32'h0;

      // ---- reset state ----
      tick();
      settle();
      check_offer("reset", 1'b1, 32'h1C00_0000, 32'h0);

      // ---- basic fetch, 1-cycle ICache ----
      rst = 1'b0;
      icache_req_ready = 1'b1;
      settle();
      check_req("t1_c1", 1'b1, 32'h1C00_0000);
      check("t1_c1_bubble", {31'd0, IF1_bubble_out}, 32'd1);
      tick();
      icache_req_ready  = 1'b0;
      icache_resp_valid = 1'b1;
      icache_resp_inst  = 32'h0280_0000;
      settle();
      check_offer("t1_c2", 1'b0, 32'h1C00_0000, 32'h0280_0000);
      check("t1_c2_no_req", {31'd0, icache_req_valid}, 32'd0);
      tick();
      icache_resp_valid = 1'b0;
      settle();
      check_req("t1_c3", 1'b1, 32'h1C00_0004);
      check("t1_c3_bubble", {31'd0, IF1_bubble_out}, 32'd1);

      // ---- response under DCache stall for 3 cycles -> HOLD ----
      icache_req_ready = 1'b1;
      tick();
      icache_req_ready  = 1'b0;
      icache_resp_valid = 1'b1;
      icache_resp_inst  = 32'hAABB_CCDD;
      stall_from_DCache = 1'b1;
      settle();
      check_offer("t2_s0", 1'b0, 32'h1C00_0004, 32'hAABB_CCDD);
      tick();
      icache_resp_valid = 1'b0;
      icache_resp_inst  = 32'h0;
      for (int i = 1; i < 3; i++) begin
         settle();
         check_offer("t2_hold", 1'b0, 32'h1C00_0004, 32'hAABB_CCDD);
         check("t2_hold_no_req", {31'd0, icache_req_valid}, 32'd0);
         tick();
      end
      stall_from_DCache = 1'b0;
      settle();
      check_offer("t2_release", 1'b0, 32'h1C00_0004, 32'hAABB_CCDD);
      tick();
      settle();
      check_req("t2_next", 1'b1, 32'h1C00_0008);
      check("t2_next_bubble", {31'd0, IF1_bubble_out}, 32'd1);

      // ---- redirect while request outstanding -> DROP ----
      icache_req_ready = 1'b1;
      tick();
      icache_req_ready = 1'b0;
      redirect_valid   = 1'b1;
      redirect_target  = 32'h1C00_0100;
      settle();
      check("t3_redir_bubble", {31'd0, IF1_bubble_out}, 32'd1);
      tick();
      redirect_valid = 1'b0;
      settle();
      check_req("t3_drop1", 1'b0, 32'h1C00_0100);
      check("t3_drop1_bubble", {31'd0, IF1_bubble_out}, 32'd1);
      tick();
      icache_resp_valid = 1'b1;
      icache_resp_inst  = 32'hDEAD_BEEF;
      settle();
      check_offer("t3_stale", 1'b1, 32'h1C00_0100, 32'h0);
      check("t3_stale_no_req", {31'd0, icache_req_valid}, 32'd0);
      tick();
      icache_resp_valid = 1'b0;
      settle();
      check_req("t3_next", 1'b1, 32'h1C00_0100);

      // ---- redirect coincident with resp in WAIT, load stall masked ----
      icache_req_ready = 1'b1;
      tick();
      icache_req_ready  = 1'b0;
      icache_resp_valid = 1'b1;
      icache_resp_inst  = 32'h1234_5678;
      redirect_valid    = 1'b1;
      redirect_target   = 32'h1C00_0200;
      stall_from_Load   = 1'b1;
      settle();
      check_offer("t4_coinc", 1'b1, 32'h1C00_0100, 32'h0);
      tick();
      icache_resp_valid = 1'b0;
      redirect_valid    = 1'b0;
      stall_from_Load   = 1'b0;
      settle();
      check_req("t4_next", 1'b1, 32'h1C00_0200);

      // load stall alone holds; redirect in HOLD overrides it
      icache_req_ready = 1'b1;
      tick();
      icache_req_ready  = 1'b0;
      icache_resp_valid = 1'b1;
      icache_resp_inst  = 32'h1111_2222;
      stall_from_Load   = 1'b1;
      tick();
      icache_resp_valid = 1'b0;
      settle();
      check_offer("t4_hold", 1'b0, 32'h1C00_0200, 32'h1111_2222);
      redirect_valid  = 1'b1;
      redirect_target = 32'h1C00_0300;
      tick();
      redirect_valid  = 1'b0;
      stall_from_Load = 1'b0;
      settle();
      check_req("t4_hold_redir", 1'b1, 32'h1C00_0300);
      check("t4_hold_redir_bubble", {31'd0, IF1_bubble_out}, 32'd1);

      // ---- req_ready low for 5 cycles, then redirect while waiting ----
      for (int i = 0; i < 5; i++) begin
         settle();
         check_req("t5_wait", 1'b1, 32'h1C00_0300);
         tick();
      end
      redirect_valid  = 1'b1;
      redirect_target = 32'h1C00_0400;
      settle();
      check("t5_redir_no_req", {31'd0, icache_req_valid}, 32'd0);
      tick();
      redirect_valid = 1'b0;
      settle();
      check_req("t5_retarget", 1'b1, 32'h1C00_0400);

      // ---- reset mid-WAIT ----
      icache_req_ready = 1'b1;
      tick();
      icache_req_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      check_req("t6_rst", 1'b1, 32'h1C00_0000);
      check_offer("t6_rst", 1'b1, 32'h1C00_0000, 32'h0);

      // unaligned redirect target is word-aligned
      redirect_valid  = 1'b1;
      redirect_target = 32'h1C00_0203;
      tick();
      redirect_valid = 1'b0;
      settle();
      check_req("t6_align", 1'b1, 32'h1C00_0200);

      // ---- PC wraps at 2^32 ----
      redirect_valid  = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      tick();
      redirect_valid   = 1'b0;
      icache_req_ready = 1'b1;
      settle();
      check_req("t7_top", 1'b1, 32'hFFFF_FFFC);
      tick();
      icache_req_ready  = 1'b0;
      icache_resp_valid = 1'b1;
      icache_resp_inst  = 32'h0000_0013;
      settle();
      check_offer("t7_offer", 1'b0, 32'hFFFF_FFFC, 32'h0000_0013);
      tick();
      icache_resp_valid = 1'b0;
      settle();
      check_req("t7_wrap", 1'b1, 32'h0000_0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
